// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the PC, picks the next PC by priority, drives the
// synchronous instruction ROM and squashes the wrong-path word on redirects.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter logic [31:0] EXCEPTION_VECTOR = 32'h0000_F000,
  parameter int          ROM_ADDR_WIDTH   = 14
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      Stall,
  input  logic                      Redirect,
  input  logic [31:0]               Redirect_target,
  input  logic                      Exception,
  input  logic                      Eret,
  input  logic [31:0]               Epc,
  output logic [ROM_ADDR_WIDTH-1:0] Rom_address,
  input  logic [31:0]               Rom_data,
  output logic [31:0]               PC_out,
  output logic [31:0]               PC_plus_4_out,
  output logic [31:0]               PC_plus_4_latch_out,
  output logic [31:0]               Instruction_out,
  output logic                      Valid_out,
  output logic                      Address_error_out
);

  logic [31:0] r_pc;
  logic [31:0] r_pc_plus_4_latch;
  logic        r_valid;
  logic        r_addr_error;

  logic [31:0] w_pc_plus_4;
  logic [31:0] w_next_pc_raw;
  logic [31:0] w_next_pc;
  logic        w_misaligned;
  logic        w_redirect_any;

  assign w_pc_plus_4    = r_pc + 32'd4;
  assign w_redirect_any = Redirect | Exception | Eret;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_next_pc_raw = w_pc_plus_4;
    w_misaligned  = 1'b0;
    if (reset) begin
      w_next_pc_raw = RESET_PC;
    end else if (Exception) begin
      w_next_pc_raw = EXCEPTION_VECTOR;
    end else if (Eret) begin
      w_next_pc_raw = Epc;
      w_misaligned  = |Epc[1:0];
    end else if (Redirect) begin
      w_next_pc_raw = Redirect_target;
      w_misaligned  = |Redirect_target[1:0];
    end else if (Stall) begin
      w_next_pc_raw = r_pc;
    end
  end

  // The PC is always word aligned; a misaligned target is truncated and flagged.
  assign w_next_pc   = {w_next_pc_raw[31:2], 2'b00};
  assign Rom_address = w_next_pc[ROM_ADDR_WIDTH+1:2];

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      r_pc              <= {RESET_PC[31:2], 2'b00};
      r_pc_plus_4_latch <= 32'h0000_0000;
      r_valid           <= 1'b0;
      r_addr_error      <= 1'b0;
    end else begin
      r_pc         <= w_next_pc;
      r_valid      <= 1'b1;
      r_addr_error <= w_misaligned;
      if (!Stall || w_redirect_any) begin
        r_pc_plus_4_latch <= w_pc_plus_4;
      end
    end
  end

  assign PC_out              = r_pc;
  assign PC_plus_4_out       = w_pc_plus_4;
  assign PC_plus_4_latch_out = r_pc_plus_4_latch;
  assign Valid_out           = r_valid & ~w_redirect_any;
  assign Instruction_out     = Valid_out ? Rom_data : 32'h0000_0000;
  assign Address_error_out   = r_addr_error;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed test-plan steps followed by
// random traffic, all checked against a cycle-level reference model.
module tb_instruction_fetch;

  localparam int AW = 14;

  logic          clock = 1'b0;
  logic          reset, Stall, Redirect, Exception, Eret;
  logic [31:0]   Redirect_target, Epc;
  logic [AW-1:0] Rom_address;
  logic [31:0]   Rom_data;
  logic [31:0]   PC_out, PC_plus_4_out, PC_plus_4_latch_out, Instruction_out;
  logic          Valid_out, Address_error_out;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_pc, m_latch;
  logic        m_valid, m_aerr;

  instruction_fetch dut (
    .clock(clock), .reset(reset), .Stall(Stall), .Redirect(Redirect),
    .Redirect_target(Redirect_target), .Exception(Exception), .Eret(Eret), .Epc(Epc),
    .Rom_address(Rom_address), .Rom_data(Rom_data), .PC_out(PC_out),
    .PC_plus_4_out(PC_plus_4_out), .PC_plus_4_latch_out(PC_plus_4_latch_out),
    .Instruction_out(Instruction_out), .Valid_out(Valid_out),
    .Address_error_out(Address_error_out)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_f(input logic [AW-1:0] a);
    return {a, 2'b01, ~a[7:0], a[7:0]} ^ 32'h5A5A_0000;
  endfunction

  // Synchronous ROM: read registered on the rising edge.
  always @(posedge clock) Rom_data <= rom_f(Rom_address);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
  task automatic cycle(input logic rst, input logic st, input logic rd, input logic [31:0] tgt,
                       input logic ex, input logic er, input logic [31:0] ep);
    logic [31:0] exp_next;
    logic        exp_valid;
    reset = rst; Stall = st; Redirect = rd; Redirect_target = tgt;
    Exception = ex; Eret = er; Epc = ep;
    if (rst)     exp_next = 32'h0;
    else if (ex) exp_next = 32'h0000_F000;
    else if (er) exp_next = ep & ~32'h3;
    else if (rd) exp_next = tgt & ~32'h3;
    else if (st) exp_next = m_pc;
    else         exp_next = m_pc + 32'd4;
    exp_valid = m_valid && !rd && !ex && !er;
    @(negedge clock);
    check("pc", PC_out, m_pc);
    check("pc_plus_4", PC_plus_4_out, m_pc + 32'd4);
    check("latch", PC_plus_4_latch_out, m_latch);
    check("valid", {31'd0, Valid_out}, {31'd0, exp_valid});
    check("instr", Instruction_out, exp_valid ? rom_f(m_pc[AW+1:2]) : 32'h0);
    check("addr_err", {31'd0, Address_error_out}, {31'd0, m_aerr});
    check("rom_addr", {{(32-AW){1'b0}}, Rom_address}, {{(32-AW){1'b0}}, exp_next[AW+1:2]});
    @(posedge clock);
    if (rst) begin
      m_pc = 32'h0; m_latch = 32'h0; m_valid = 1'b0; m_aerr = 1'b0;
    end else begin
      if (!st || rd || ex || er) m_latch = m_pc + 32'd4;
      m_aerr  = !ex && (er ? (ep[1:0] != 2'b00) : (rd && tgt[1:0] != 2'b00));
      m_pc    = exp_next;
      m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; Redirect_target = 32'h0;
    Exception = 1'b0; Eret = 1'b0; Epc = 32'h0;
    m_pc = 32'h0; m_latch = 32'h0; m_valid = 1'b0; m_aerr = 1'b0;

    // Reset release.
    @(posedge clock); #1;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rst_pc", PC_out, 32'h0);
    check("rst_valid", {31'd0, Valid_out}, 32'd0);
    idle(1);
    check("first_pc", PC_out, 32'h4);
    check("first_latch", PC_plus_4_latch_out, 32'h4);

    // Sequential fetch and stall.
    idle(3);
    check("seq_pc", PC_out, 32'h10);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("stall_pc", PC_out, 32'h10);
      check("stall_latch", PC_plus_4_latch_out, 32'h10);
    end
    idle(1);
    check("post_stall_pc", PC_out, 32'h14);

    // Redirect.
    idle(3);
    check("pre_redir_pc", PC_out, 32'h20);
    cycle(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    check("redir_pc", PC_out, 32'h100);
    idle(1);

    // Priority.
    cycle(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'h40);
    check("prio_exc", PC_out, 32'h0000_F000);
    cycle(1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 1'b1, 32'h40);
    check("prio_eret", PC_out, 32'h40);

    // Misaligned redirect target.
    cycle(1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 1'b0, 32'h0);
    check("mis_pc", PC_out, 32'h100);
    check("mis_err", {31'd0, Address_error_out}, 32'd1);
    idle(1);
    check("mis_err_clear", {31'd0, Address_error_out}, 32'd0);

    // Wrap, then reset during a stall.
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    idle(1);
    check("wrap_pc", PC_out, 32'h0);
    idle(2);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rst_mid_pc", PC_out, 32'h0);
    check("rst_mid_latch", PC_plus_4_latch_out, 32'h0);
    idle(2);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt, ep;
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      ep  = $urandom;
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
            tgt, $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0, ep);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch (IF) stage of the Minisys-1A five-stage pipeline. It holds the program counter, selects the next PC, drives the synchronous instruction ROM and presents the fetched word to the IF/ID pipeline register. It delivers PC+4 and the previous-cycle PC+4 ("latch") values to IF/ID. Redirects from ID, exceptions and ERET squash the wrong-path word by presenting a NOP.

## Interface
- RESET_PC, 32'h0000_0000: PC value after reset.
- EXCEPTION_VECTOR, 32'h0000_F000: PC loaded when Exception is asserted.
- ROM_ADDR_WIDTH, 14: word-address width of the instruction ROM.
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Stall  input  1  ID hazard unit: hold the PC and latch registers.
- Redirect  input  1  branch or jump resolved taken in ID.
- Redirect_target  input  32  target PC for Redirect.
- Exception  input  1  CP0 exception request.
- Eret  input  1  return from exception.
- Epc  input  32  return address for Eret.
- Rom_address  output  ROM_ADDR_WIDTH  word address to ROM; combinational from next PC.
- Rom_data  input  32  ROM read data, registered inside the ROM on the rising edge.
- PC_out  output  32  PC of the word currently in IF.
- PC_plus_4_out  output  32  PC_out + 4.
- PC_plus_4_latch_out  output  32  PC_plus_4_out captured at the last non-stalled edge.
- Instruction_out  output  32  Rom_data when Valid_out = 1, else 32'h0000_0000 (NOP).
- Valid_out  output  1  the current IF word is on the correct path.
- Address_error_out  output  1  one-cycle pulse: a misaligned redirect target was seen.

## Operation
- Next-PC priority, highest first:
  - reset → RESET_PC
  - Exception → EXCEPTION_VECTOR
  - Eret → Epc
  - Redirect → Redirect_target
  - Stall → PC (hold)
  - otherwise PC + 4
- Next-PC bits [1:0] are forced to 00. If the selected redirect target or Epc has non-zero bits [1:0], Address_error_out = 1 in the following cycle. The PC still loads the truncated value.
- Rom_address = next_pc[ROM_ADDR_WIDTH+1:2]. Because the ROM registers its read, Rom_data always matches PC_out after each edge, including stall cycles, where the same word is re-read.
- valid_r register:
  - cleared by reset.
  - set to 1 at the first edge after reset deasserts.
  - otherwise stays 1.
- Valid_out = valid_r & ~Redirect & ~Exception & ~Eret. The word in IF is squashed in the same cycle the redirect source is asserted. There are no branch delay slots.
- PC_plus_4_latch register loads PC_plus_4_out on every edge with Stall = 0 or any redirect-class input asserted. It holds while only Stall is asserted.
- Arithmetic: PC + 4 is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag. ROM address bits above ROM_ADDR_WIDTH+1 are ignored, so the ROM aliases.
- Simultaneous events:
  - Exception overrides Eret, Redirect and Stall.
  - Redirect overrides Stall; the hazard unit should not assert both, but the block must behave as listed.

## Timing
- Reset values (while reset is high and at the first edge after): PC_out = RESET_PC, PC_plus_4_out = RESET_PC + 4, PC_plus_4_latch_out = 0, valid_r = 0, Valid_out = 0, Instruction_out = 0, Address_error_out = 0.
- Reset asserted mid-operation: all registers take their reset values at that edge, overriding every other input.
- Latency:
  - Redirect, Exception or Eret asserted in cycle N → PC_out = target in cycle N+1, with valid instruction data.
  - Exactly one word (the IF word of cycle N) is squashed.
- Stall in cycle N → PC_out, Rom_data and PC_plus_4_latch_out are unchanged in cycle N+1. Valid_out is unaffected by Stall.
- Rom_address is combinational from the inputs. It must settle before the rising edge; the IF/ID register samples the outputs on the falling edge.

## Test plan
- Reset release: reset high for 2 cycles, then low → PC_out = 0 with Valid_out = 0. Next edge: PC_out = 4, Valid_out = 1, Instruction_out = ROM[1], PC_plus_4_latch_out = 4.
- Sequential fetch and stall: run to PC_out = 0x10, hold Stall for 3 cycles → PC_out stays 0x10, Instruction_out = ROM[4] throughout, PC_plus_4_latch_out stays 0x10. After release → PC_out = 0x14.
- Redirect: at PC_out = 0x20, pulse Redirect with target 0x100 → Valid_out = 0 and Instruction_out = 0 that cycle. Next cycle: PC_out = 0x100, Instruction_out = ROM[0x40].
- Priority: assert Exception, Eret (Epc = 0x40), Redirect (0x80) and Stall together → next PC_out = 0xF000. The same inputs without Exception → PC_out = 0x40.
- Misaligned target: Redirect with target 0x103 → next PC_out = 0x100 and Address_error_out = 1 for exactly one cycle.
- Wrap and reset mid-stall: redirect to 0xFFFF_FFFC, then one sequential step → PC_out = 0. Then assert reset during Stall → PC_out = RESET_PC and PC_plus_4_latch_out = 0 at that edge.
